// File: rtl/mem_wb_pkg.sv
// MEM/WB stage shared definitions.
// Load-size encodings and width helpers.
package mem_wb_pkg;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
  localparam logic [1:0] LS_FULL = 2'b11;

  function automatic int off_w(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/mem_wb_if.sv
// MEM/WB stage bundle: MEM-side inputs and WB-side outputs.
// slave is the stage itself, master is whoever drives it.
interface mem_wb_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  localparam int OFF_W = off_w(DATA_W);

  logic                  stall;
  logic                  flush;
  logic                  counter_clear;
  logic                  in_valid;
  logic [REG_ADDR_W-1:0] write_register;
  logic [DATA_W-1:0]     alu_out;
  logic [DATA_W-1:0]     memory_out;
  logic                  reg_write;
  logic                  mem_to_reg;
  logic [1:0]            load_size;
  logic                  load_unsigned;
  logic [OFF_W-1:0]      byte_offset;
  logic                  out_valid;
  logic [REG_ADDR_W-1:0] write_register_out;
  logic [DATA_W-1:0]     write_data_out;
  logic                  reg_write_out;
  logic [CNT_W-1:0]      retired_count;

  modport slave (
    input  stall, flush, counter_clear, in_valid,
    input  write_register, alu_out, memory_out,
    input  reg_write, mem_to_reg, load_size,
    input  load_unsigned, byte_offset,
    output out_valid, write_register_out,
    output write_data_out, reg_write_out,
    output retired_count
  );

  modport master (
    output stall, flush, counter_clear, in_valid,
    output write_register, alu_out, memory_out,
    output reg_write, mem_to_reg, load_size,
    output load_unsigned, byte_offset,
    input  out_valid, write_register_out,
    input  write_data_out, reg_write_out,
    input  retired_count
  );
endinterface

// File: rtl/mem_wb_stage_p_load_extend.sv
// Sub-word load alignment and sign/zero extension.
// Purely combinational; misalignment is not checked here.
module load_extend
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [DATA_W-1:0] memory_out,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [OFF_W-1:0]  byte_offset,
  output logic [DATA_W-1:0] load_data
);
  logic [OFF_W-1:0]  w_off;
  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_mask;
  logic              w_sign;
  logic              w_ext;

  // Halfwords ignore the low offset bit.
  always_comb begin
    w_off = byte_offset;
    if (load_size == LS_HALF) w_off[0] = 1'b0;
  end

  assign w_sh = memory_out >> {w_off, 3'b000};

  always_comb begin
    w_mask = '1;
    w_sign = 1'b0;
    unique case (load_size)
      LS_BYTE: begin
        w_mask = DATA_W'(8'hFF);
        w_sign = w_sh[7];
      end
      LS_HALF: begin
        w_mask = DATA_W'(16'hFFFF);
        w_sign = w_sh[15];
      end
      LS_WORD: begin
        w_mask = DATA_W'(32'hFFFF_FFFF);
        w_sign = w_sh[31];
      end
      default: ;
    endcase
  end

  assign w_ext = w_sign & ~load_unsigned;

  assign load_data = (load_size == LS_FULL)
                   ? memory_out
                   : (w_sh & w_mask)
                   | ({DATA_W{w_ext}} & ~w_mask);
endmodule

// File: rtl/mem_wb_stage_p.sv
// MEM/WB pipeline register with writeback mux,
// stall/flush, r0 guard and saturating retire counter.
module mem_wb_stage_p
  import mem_wb_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_W          = 32,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input logic   clock,
  input logic   reset,
  mem_wb_if.slave bus
);
  localparam int OFF_W = off_w(DATA_W);

  logic [DATA_W-1:0]     w_ld_data;
  logic [DATA_W-1:0]     w_wb_data;
  logic                  w_we;
  logic                  w_load;
  logic                  r_valid;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_wr;
  logic [DATA_W-1:0]     r_data;
  logic [CNT_W-1:0]      r_cnt;

  load_extend #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_ext (
    .memory_out    (bus.memory_out),
    .load_size     (bus.load_size),
    .load_unsigned (bus.load_unsigned),
    .byte_offset   (bus.byte_offset),
    .load_data     (w_ld_data)
  );

  assign w_wb_data = bus.mem_to_reg ? w_ld_data
                                    : bus.alu_out;

  assign w_we = bus.reg_write & bus.in_valid
              & ~(ZERO_REG_GUARD
                  && (bus.write_register == '0));

  assign w_load = ~bus.flush & ~bus.stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_wr    <= '0;
      r_data  <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_wr    <= '0;
      r_data  <= '0;
    end else if (!bus.stall) begin
      r_valid <= bus.in_valid;
      r_we    <= w_we;
      r_wr    <= bus.write_register;
      r_data  <= w_wb_data;
    end
  end

  // Clear beats increment; count sticks at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (bus.counter_clear) begin
      r_cnt <= '0;
    end else if (w_load && bus.in_valid
                 && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.out_valid          = r_valid;
  assign bus.reg_write_out      = r_we;
  assign bus.write_register_out = r_wr;
  assign bus.write_data_out     = r_data;
  assign bus.retired_count      = r_cnt;
endmodule

// File: tb/tb_mem_wb_stage_p.sv
// Directed bench for mem_wb_stage_p.
// CNT_W=4 so counter saturation is reachable.
module tb_mem_wb_stage_p;
  import mem_wb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;

  mem_wb_if #(
    .DATA_W     (DW),
    .REG_ADDR_W (AW),
    .CNT_W      (CW)
  ) bus ();

  mem_wb_stage_p #(
    .DATA_W         (DW),
    .REG_ADDR_W     (AW),
    .CNT_W          (CW),
    .ZERO_REG_GUARD (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] v,
                         input logic [31:0] we,
                         input logic [31:0] wr,
                         input logic [31:0] d,
                         input logic [31:0] c);
    chk({tag, ".valid"}, 32'(bus.out_valid), v);
    chk({tag, ".we"}, 32'(bus.reg_write_out), we);
    chk({tag, ".wr"},
        32'(bus.write_register_out), wr);
    chk({tag, ".data"}, bus.write_data_out, d);
    chk({tag, ".cnt"}, 32'(bus.retired_count), c);
  endtask

  task automatic ld(input logic [1:0] sz,
                    input logic us,
                    input logic [1:0] off);
    bus.mem_to_reg    = 1'b1;
    bus.load_size     = sz;
    bus.load_unsigned = us;
    bus.byte_offset   = off;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.counter_clear  = 1'b0;
    bus.in_valid       = 1'b0;
    bus.write_register = '0;
    bus.alu_out        = '0;
    bus.memory_out     = '0;
    bus.reg_write      = 1'b0;
    bus.mem_to_reg     = 1'b0;
    bus.load_size      = LS_WORD;
    bus.load_unsigned  = 1'b0;
    bus.byte_offset    = '0;
    #12;
    chk_all("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;

    bus.in_valid       = 1'b1;
    bus.reg_write      = 1'b1;
    bus.write_register = 5'd7;
    bus.alu_out        = 32'h1234_5678;
    step();
    chk_all("alu", 1, 1, 7, 32'h1234_5678, 1);

    bus.write_register = 5'd3;
    bus.memory_out     = 32'h80FF_7F01;
    ld(LS_BYTE, 1'b0, 2'd3);
    step();
    chk("lb3", bus.write_data_out, 32'hFFFF_FF80);
    ld(LS_BYTE, 1'b1, 2'd3);
    step();
    chk("lbu3", bus.write_data_out, 32'h0000_0080);
    ld(LS_HALF, 1'b0, 2'd2);
    step();
    chk("lh2", bus.write_data_out, 32'hFFFF_80FF);
    ld(LS_BYTE, 1'b0, 2'd1);
    step();
    chk("lb1", bus.write_data_out, 32'h0000_007F);
    ld(LS_HALF, 1'b0, 2'd3);
    step();
    chk("lh3", bus.write_data_out, 32'hFFFF_80FF);
    ld(LS_HALF, 1'b1, 2'd0);
    step();
    chk("lhu0", bus.write_data_out, 32'h0000_7F01);
    ld(LS_WORD, 1'b0, 2'd0);
    step();
    chk_all("lw", 1, 1, 3, 32'h80FF_7F01, 8);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_to_reg     = 1'b0;
      bus.alu_out        = 32'hDEAD_0000 + i;
      bus.write_register = 5'(9 + i);
      step();
      chk_all("stall", 1, 1, 3, 32'h80FF_7F01, 8);
    end

    bus.flush = 1'b1;
    step();
    chk_all("stfl", 0, 0, 0, 0, 8);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    bus.write_register = 5'd0;
    bus.alu_out        = 32'h55;
    step();
    chk_all("r0", 1, 0, 0, 32'h55, 9);

    bus.in_valid       = 1'b0;
    bus.write_register = 5'd5;
    step();
    chk_all("inv", 0, 0, 5, 32'h55, 9);

    bus.in_valid      = 1'b1;
    bus.counter_clear = 1'b1;
    step();
    chk("clr", 32'(bus.retired_count), 0);
    bus.counter_clear = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("sat", 32'(bus.retired_count), 15);
    bus.counter_clear = 1'b1;
    step();
    chk("clrsat", 32'(bus.retired_count), 0);
    chk("clrv", 32'(bus.out_valid), 1);
    bus.counter_clear = 1'b0;

    step();
    chk("pre", 32'(bus.retired_count), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("arst", 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    chk_all("hold", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
